// File: rtl/peripheral_operand_sequencer_if.sv
// Byte handshake from the serial receiver plus the operand-register write bus.
// master = receiver/downstream side, slave = the sequencer.
interface peripheral_operand_sequencer_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       start;
  logic [7:0] inputdata;
  logic       loaddata;
  logic [3:0] datainput_i;
  logic       busy;
  logic       done;
  logic       timeout_err;

  modport master (
    output rx_data, rx_valid, start,
    input  rx_ready, inputdata, loaddata, datainput_i, busy, done, timeout_err
  );

  modport slave (
    input  rx_data, rx_valid, start,
    output rx_ready, inputdata, loaddata, datainput_i, busy, done, timeout_err
  );
endinterface

// File: rtl/peripheral_operand_sequencer.sv
// Collects an 8-byte operand frame (A then B, LSB first) from a byte stream and
// strobes each byte into the operand register stage, aborting on inter-byte timeout.
module peripheral_operand_sequencer #(
  parameter int TIMEOUT = 50000
) (
  input logic clk,
  input logic reset,
  peripheral_operand_sequencer_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TLIMIT = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TSAT   = {TW{1'b1}};

  typedef enum logic [2:0] {IDLE, WAIT_BYTE, LOAD, DONE, ERR} state_t;

  state_t        state, next_state;
  logic [2:0]    index;
  logic [TW-1:0] timer;
  logic          accept;
  logic          expired;

  // The first byte of a frame may take arbitrarily long, so the timer only arms once index moves on.
  assign accept  = (state == WAIT_BYTE) && bus.rx_valid;
  assign expired = (index != 3'd0) && (timer >= TLIMIT);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // An accept in the same cycle the timer hits its limit still wins.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:      if (bus.start) next_state = WAIT_BYTE;
      WAIT_BYTE: begin
        if (accept)       next_state = LOAD;
        else if (expired) next_state = ERR;
      end
      LOAD:      next_state = (index == 3'd7) ? DONE : WAIT_BYTE;
      DONE:      next_state = IDLE;
      ERR:       next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.rx_ready    = 1'b0;
    bus.busy        = 1'b0;
    bus.loaddata    = 1'b0;
    bus.done        = 1'b0;
    bus.timeout_err = 1'b0;
    case (state)
      WAIT_BYTE: begin
        bus.rx_ready = 1'b1;
        bus.busy     = 1'b1;
      end
      LOAD: begin
        bus.loaddata = 1'b1;
        bus.busy     = 1'b1;
      end
      DONE:    bus.done        = 1'b1;
      ERR:     bus.timeout_err = 1'b1;
      default: ;
    endcase
  end

  // Slot index, inter-byte timer and the held write bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      index           <= 3'd0;
      timer           <= '0;
      bus.inputdata   <= 8'h00;
      bus.datainput_i <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            index <= 3'd0;
            timer <= '0;
          end
        end
        WAIT_BYTE: begin
          if (accept) begin
            bus.inputdata   <= bus.rx_data;
            bus.datainput_i <= {1'b0, index};
          end else if ((index != 3'd0) && (timer != TSAT)) begin
            timer <= timer + TW'(1);
          end
        end
        LOAD: begin
          if (index != 3'd7) begin
            index <= index + 3'd1;
            timer <= '0;
          end
        end
        DONE:    index <= 3'd0;
        ERR:     index <= 3'd0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_peripheral_operand_sequencer.sv
// Directed and randomized frames checked against a transaction-level model of
// expected strobes, done/timeout pulses and their cycle positions.
module tb_peripheral_operand_sequencer;
  localparam int TIMEOUT = 8;
  localparam int BOUND   = 200;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  peripheral_operand_sequencer_if bus ();

  peripheral_operand_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int ldCyc[$];
  int ldSlot[$];
  int ldByte[$];
  int doneCyc[$];
  int errCyc[$];

  logic [7:0]  sent[8];
  int          accCyc[8];
  int          nSent;
  logic [31:0] lastA, lastB;

  // Observed strobes/pulses, stamped with the cycle they were visible in.
  always @(negedge clk) begin
    if (bus.loaddata === 1'b1) begin
      ldCyc.push_back(cyc);
      ldSlot.push_back(int'(bus.datainput_i));
      ldByte.push_back(int'(bus.inputdata));
    end
    if (bus.done === 1'b1)        doneCyc.push_back(cyc);
    if (bus.timeout_err === 1'b1) errCyc.push_back(cyc);
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic clearObs();
    ldCyc.delete();
    ldSlot.delete();
    ldByte.delete();
    doneCyc.delete();
    errCyc.delete();
  endtask

  task automatic startFrame();
    clearObs();
    nSent = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Offer one byte after gap idle cycles and hold it until the sequencer takes it.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int waited;
    repeat (gap) @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    waited = 0;
    while (bus.rx_ready !== 1'b1 && waited < BOUND) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("rx_ready_seen", 64'(bus.rx_ready), 64'(1));
    if (bus.rx_ready === 1'b1) begin
      if (nSent < 8) begin
        sent[nSent]   = b;
        accCyc[nSent] = cyc;
        nSent++;
      end
      @(negedge clk);
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_rx_ready"},    64'(bus.rx_ready),    64'(0));
    checkOutput({tag, "_busy"},        64'(bus.busy),        64'(0));
    checkOutput({tag, "_loaddata"},    64'(bus.loaddata),    64'(0));
    checkOutput({tag, "_done"},        64'(bus.done),        64'(0));
    checkOutput({tag, "_timeout_err"}, 64'(bus.timeout_err), 64'(0));
    checkOutput({tag, "_inputdata"},   64'(bus.inputdata),   64'(0));
    checkOutput({tag, "_datainput_i"}, 64'(bus.datainput_i), 64'(0));
  endtask

  // Model: strobe i carries slot i and the i-th sent byte one cycle after its accept;
  // done lands two cycles after the 8th accept; timeout lands TIMEOUT cycles after leaving the last LOAD.
  task automatic checkFrame(input string tag, input int nExp, input bit expDone, input bit expErr);
    logic [31:0] expA, expB;
    repeat (TIMEOUT + 4) @(negedge clk);
    checkOutput({tag, "_strobes"}, 64'(ldCyc.size()), 64'(nExp));
    for (int i = 0; i < nExp && i < ldCyc.size(); i++) begin
      checkOutput($sformatf("%s_slot%0d", tag, i), 64'(ldSlot[i]), 64'(i));
      checkOutput($sformatf("%s_byte%0d", tag, i), 64'(ldByte[i]), 64'(sent[i]));
      checkOutput($sformatf("%s_lat%0d", tag, i),  64'(ldCyc[i]),  64'(accCyc[i] + 1));
    end
    checkOutput({tag, "_done_count"}, 64'(doneCyc.size()), 64'(expDone));
    if (expDone && doneCyc.size() > 0 && nSent > 0)
      checkOutput({tag, "_done_cycle"}, 64'(doneCyc[0]), 64'(accCyc[nSent-1] + 2));
    checkOutput({tag, "_err_count"}, 64'(errCyc.size()), 64'(expErr));
    if (expErr && errCyc.size() > 0 && nSent > 0)
      checkOutput({tag, "_err_cycle"}, 64'(errCyc[0]), 64'(accCyc[nSent-1] + 2 + TIMEOUT));
    lastA = '0;
    lastB = '0;
    for (int i = 0; i < ldSlot.size(); i++) begin
      if (ldSlot[i] >= 0 && ldSlot[i] < 4)      lastA[ldSlot[i]*8 +: 8] = 8'(ldByte[i]);
      else if (ldSlot[i] >= 4 && ldSlot[i] < 8) lastB[(ldSlot[i]-4)*8 +: 8] = 8'(ldByte[i]);
    end
    if (nExp == 8) begin
      expA = 32'(sent[0]) | (32'(sent[1]) << 8) | (32'(sent[2]) << 16) | (32'(sent[3]) << 24);
      expB = 32'(sent[4]) | (32'(sent[5]) << 8) | (32'(sent[6]) << 16) | (32'(sent[7]) << 24);
      checkOutput({tag, "_dataA"}, 64'(lastA), 64'(expA));
      checkOutput({tag, "_dataB"}, 64'(lastB), 64'(expB));
    end
    checkOutput({tag, "_idle_busy"}, 64'(bus.busy), 64'(0));
  endtask

  task automatic randomFrame(input string tag, input int firstGap);
    startFrame();
    applyStimulus(8'($urandom_range(0, 255)), firstGap);
    for (int i = 1; i < 8; i++)
      applyStimulus(8'($urandom_range(0, 255)), int'($urandom_range(0, TIMEOUT)));
    checkFrame(tag, 8, 1'b1, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    nSent        = 0;
    repeat (3) @(negedge clk);
    checkReset("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Directed frame 11..88 with rx_valid offered back to back.
    $display("[TB] directed frame");
    startFrame();
    checkOutput("wait_busy",     64'(bus.busy),     64'(1));
    checkOutput("wait_rx_ready", 64'(bus.rx_ready), 64'(1));
    for (int i = 0; i < 8; i++) applyStimulus(8'((i + 1) * 17), 0);
    checkFrame("basic", 8, 1'b1, 1'b0);
    checkOutput("basic_dataA_const", 64'(lastA), 64'(32'h44332211));
    checkOutput("basic_dataB_const", 64'(lastB), 64'(32'h88776655));

    // Long wait before the first byte never times out.
    $display("[TB] long first-byte wait");
    randomFrame("first_wait", 100);

    // Every later byte arrives on the last allowed cycle.
    $display("[TB] accept at timeout boundary");
    startFrame();
    applyStimulus(8'($urandom_range(0, 255)), 0);
    for (int i = 1; i < 8; i++) applyStimulus(8'($urandom_range(0, 255)), TIMEOUT);
    checkFrame("boundary", 8, 1'b1, 1'b0);

    // Three bytes then silence: abandoned frame.
    $display("[TB] inter-byte timeout");
    startFrame();
    for (int i = 0; i < 3; i++) applyStimulus(8'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
    checkFrame("timeout", 3, 1'b0, 1'b1);
    randomFrame("after_timeout", 2);

    // Reset right after the 5th strobe.
    $display("[TB] mid-frame reset");
    startFrame();
    for (int i = 0; i < 5; i++) applyStimulus(8'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
    reset = 1'b1;
    @(negedge clk);
    checkReset("midreset");
    reset = 1'b0;
    checkFrame("midreset", 5, 1'b0, 1'b0);
    randomFrame("after_reset", 0);

    // rx_valid in IDLE, together with start, and a stray start mid-frame.
    $display("[TB] ignored start and rx_valid");
    clearObs();
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hEE;
    repeat (3) @(negedge clk);
    checkOutput("idle_no_strobe",   64'(ldCyc.size()), 64'(0));
    checkOutput("idle_no_rx_ready", 64'(bus.rx_ready), 64'(0));
    startFrame();
    bus.rx_valid = 1'b0;
    applyStimulus(8'h5A, 1);
    applyStimulus(8'hA5, 0);
    bus.start = 1'b1;
    repeat (2) @(negedge clk);
    bus.start = 1'b0;
    for (int i = 2; i < 8; i++) applyStimulus(8'($urandom_range(0, 255)), 0);
    checkFrame("stray_start", 8, 1'b1, 1'b0);

    for (int f = 0; f < 4; f++)
      randomFrame($sformatf("rand%0d", f), int'($urandom_range(0, 20)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
